peripheral_bus_fabric: RTL and testbench

Parametrised peripheral interconnect between the core's peripheral port and NUM_SLAVES memory-mapped devices. It replaces direct point-to-point wiring of a single peripheral.
- Decodes the address against per-slave base/mask windows and routes the request to one slave.
- Registers the selected slave's read data and returns a one-cycle response to the master.
- Returns an error response for unmapped addresses, malformed requests and slave timeouts.
- Maintains a saturating error counter.

---
 rtl/peripheral_bus_fabric.sv | 125 ++++++++++++
 tb/tb_peripheral_bus_fabric.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_bus_fabric.sv
// Peripheral interconnect: decodes the master address against per-slave windows,
// runs one access at a time with a timeout, and returns a registered response.
module peripheral_bus_fabric #(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'h00001300, 32'h00001200, 32'h00001100, 32'h00001000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {4{32'hFFFFFF00}},
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] ERROR_DATA = 32'hDEADBEEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             master_read,
  input  logic                             master_write,
  input  logic [ADDR_WIDTH-1:0]            master_address,
  input  logic [DATA_WIDTH-1:0]            master_write_data,
  output logic [DATA_WIDTH-1:0]            master_read_data,
  output logic                             master_response,
  output logic                             master_error,
  output logic [NUM_SLAVES-1:0]            slave_read,
  output logic [NUM_SLAVES-1:0]            slave_write,
  output logic [ADDR_WIDTH-1:0]            slave_address,
  output logic [DATA_WIDTH-1:0]            slave_write_data,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slave_read_data,
  input  logic [NUM_SLAVES-1:0]            slave_response,
  output logic [7:0]                       error_count
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                  state;
  logic [15:0]             wait_cnt;
  logic [SEL_W-1:0]        sel;
  logic                    is_write;

  logic                    hit;
  logic [SEL_W-1:0]        hit_sel;
  logic [NUM_SLAVES-1:0]   hit_onehot;
  logic                    req_error;
  logic [DATA_WIDTH-1:0]   sel_data;

  // Walk from the top index down so the lowest matching window wins.
  always_comb begin
    hit     = 1'b0;
    hit_sel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((master_address & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit     = 1'b1;
        hit_sel = SEL_W'(i);
      end
    end
  end

  assign hit_onehot = NUM_SLAVES'(1) << hit_sel;
  assign req_error  = (master_read & master_write) | ((master_read ^ master_write) & ~hit);
  assign sel_data   = slave_read_data[sel*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      wait_cnt         <= '0;
      sel              <= '0;
      is_write         <= 1'b0;
      master_read_data <= '0;
      master_response  <= 1'b0;
      master_error     <= 1'b0;
      slave_read       <= '0;
      slave_write      <= '0;
      slave_address    <= '0;
      slave_write_data <= '0;
      error_count      <= '0;
    end else begin
      master_response <= 1'b0;
      master_error    <= 1'b0;
      case (state)
        IDLE: begin
          if (req_error) begin
            state            <= DONE;
            master_response  <= 1'b1;
            master_error     <= 1'b1;
            master_read_data <= ERROR_DATA;
            if (error_count != 8'hFF) error_count <= error_count + 8'd1;
          end else if (master_read || master_write) begin
            state            <= ACCESS;
            slave_address    <= master_address;
            slave_write_data <= master_write_data;
            sel              <= hit_sel;
            is_write         <= master_write;
            wait_cnt         <= '0;
            slave_read       <= master_read  ? hit_onehot : '0;
            slave_write      <= master_write ? hit_onehot : '0;
          end
        end
        ACCESS: begin
          if (slave_response[sel]) begin
            state            <= DONE;
            master_response  <= 1'b1;
            master_read_data <= is_write ? '0 : sel_data;
            slave_read       <= '0;
            slave_write      <= '0;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            state            <= DONE;
            master_response  <= 1'b1;
            master_error     <= 1'b1;
            master_read_data <= ERROR_DATA;
            slave_read       <= '0;
            slave_write      <= '0;
            if (error_count != 8'hFF) error_count <= error_count + 8'd1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_bus_fabric.sv
// Scenario bench for peripheral_bus_fabric: expected responses are queued when a
// request is driven and compared when the fabric answers.
module tb_peripheral_bus_fabric;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         master_read = 1'b0;
  logic         master_write = 1'b0;
  logic [31:0]  master_address = '0;
  logic [31:0]  master_write_data = '0;
  logic [31:0]  master_read_data;
  logic         master_response;
  logic         master_error;
  logic [3:0]   slave_read;
  logic [3:0]   slave_write;
  logic [31:0]  slave_address;
  logic [31:0]  slave_write_data;
  logic [127:0] slave_read_data = '0;
  logic [3:0]   slave_response = '0;
  logic [7:0]   error_count;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] exp_ec = 8'd0;

  peripheral_bus_fabric #(
    .NUM_SLAVES(4), .DATA_WIDTH(32), .ADDR_WIDTH(32),
    .SLAVE_BASE({32'h00001300, 32'h00001200, 32'h00001100, 32'h00001000}),
    .SLAVE_MASK({4{32'hFFFFFF00}}),
    .TIMEOUT_CYCLES(4), .ERROR_DATA(32'hDEADBEEF)
  ) dut (
    .clk(clk), .rst(rst),
    .master_read(master_read), .master_write(master_write),
    .master_address(master_address), .master_write_data(master_write_data),
    .master_read_data(master_read_data), .master_response(master_response),
    .master_error(master_error), .slave_read(slave_read), .slave_write(slave_write),
    .slave_address(slave_address), .slave_write_data(slave_write_data),
    .slave_read_data(slave_read_data), .slave_response(slave_response),
    .error_count(error_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++; if (master_response !== 1'b0) begin miscompares++; $display("FAIL reset_resp got %0b want 0", master_response); end
    vectors++; if (master_error !== 1'b0) begin miscompares++; $display("FAIL reset_err got %0b want 0", master_error); end
    vectors++; if ({slave_read, slave_write} !== 8'h00) begin miscompares++; $display("FAIL reset_strobes got %h want 00", {slave_read, slave_write}); end
    vectors++; if (master_read_data !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h want 0", master_read_data); end
    vectors++; if (slave_address !== 32'h0 || slave_write_data !== 32'h0) begin miscompares++; $display("FAIL reset_latch got %h/%h want 0/0", slave_address, slave_write_data); end
    vectors++; if (error_count !== 8'h00) begin miscompares++; $display("FAIL reset_ecount got %h want 00", error_count); end
    rst = 1'b0;
    exp_ec = 8'd0;
    tick();
  endtask

  task automatic test_read();
    slave_read_data = {32'h33333333, 32'h22222222, 32'hA5A50001, 32'h11111111};
    master_read = 1'b1; master_address = 32'h00001104;
    sb.push_back('{32'hA5A50001, 1'b0});
    tick(); // cycle 1
    vectors++; if (slave_read !== 4'b0010 || slave_write !== 4'b0000) begin miscompares++; $display("FAIL rd_strobe got %b/%b want 0010/0000", slave_read, slave_write); end
    vectors++; if (slave_address !== 32'h00001104) begin miscompares++; $display("FAIL rd_addr got %h want 00001104", slave_address); end
    vectors++; if (master_response !== 1'b0) begin miscompares++; $display("FAIL rd_early_resp got %0b want 0", master_response); end
    slave_response = 4'b0010;
    tick(); // cycle 2
    slave_response = 4'b0000;
    vectors++; if (master_response !== 1'b1) begin miscompares++; $display("FAIL rd_resp got %0b want 1", master_response); end
    vectors++; if (slave_read !== 4'b0000) begin miscompares++; $display("FAIL rd_strobe_drop got %b want 0000", slave_read); end
    vectors++;
    if (sb.size() == 0) begin miscompares++; $display("FAIL rd_sb got empty want entry"); end
    else begin
      e = sb.pop_front();
      if (master_read_data !== e.data || master_error !== e.err) begin miscompares++; $display("FAIL rd_data got %h/%0b want %h/%0b", master_read_data, master_error, e.data, e.err); end
    end
    master_read = 1'b0;
    tick();
    vectors++; if (master_response !== 1'b0) begin miscompares++; $display("FAIL rd_resp_pulse got %0b want 0", master_response); end
  endtask

  task automatic test_write();
    master_write = 1'b1; master_address = 32'h00001008; master_write_data = 32'h000000FF;
    sb.push_back('{32'h0, 1'b0});
    for (int c = 1; c <= 4; c++) begin
      tick();
      vectors++; if (slave_write !== 4'b0001 || slave_read !== 4'b0000) begin miscompares++; $display("FAIL wr_strobe c%0d got %b/%b want 0001/0000", c, slave_write, slave_read); end
      vectors++; if (master_response !== 1'b0) begin miscompares++; $display("FAIL wr_early_resp c%0d got %0b want 0", c, master_response); end
      if (c == 2) slave_response = 4'b0100; // a non-selected slave must not end the access
      if (c == 3) slave_response = 4'b0000;
      if (c == 4) slave_response = 4'b0001;
    end
    vectors++; if (slave_write_data !== 32'h000000FF) begin miscompares++; $display("FAIL wr_wdata got %h want 000000FF", slave_write_data); end
    tick(); // cycle 5
    slave_response = 4'b0000;
    vectors++; if (master_response !== 1'b1) begin miscompares++; $display("FAIL wr_resp got %0b want 1", master_response); end
    vectors++;
    if (sb.size() == 0) begin miscompares++; $display("FAIL wr_sb got empty want entry"); end
    else begin
      e = sb.pop_front();
      if (master_read_data !== e.data || master_error !== e.err) begin miscompares++; $display("FAIL wr_data got %h/%0b want %h/%0b", master_read_data, master_error, e.data, e.err); end
    end
    master_write = 1'b0;
    tick();
  endtask

  task automatic test_unmapped();
    master_read = 1'b1; master_address = 32'h00002000;
    sb.push_back('{32'hDEADBEEF, 1'b1});
    exp_ec = sat_inc(exp_ec);
    tick(); // cycle 1
    vectors++; if (master_response !== 1'b1) begin miscompares++; $display("FAIL unm_resp got %0b want 1", master_response); end
    vectors++; if (slave_read !== 4'b0000) begin miscompares++; $display("FAIL unm_strobe got %b want 0000", slave_read); end
    vectors++; if (error_count !== exp_ec) begin miscompares++; $display("FAIL unm_ecount got %h want %h", error_count, exp_ec); end
    vectors++;
    if (sb.size() == 0) begin miscompares++; $display("FAIL unm_sb got empty want entry"); end
    else begin
      e = sb.pop_front();
      if (master_read_data !== e.data || master_error !== e.err) begin miscompares++; $display("FAIL unm_data got %h/%0b want %h/%0b", master_read_data, master_error, e.data, e.err); end
    end
    master_read = 1'b0;
    tick();
  endtask

  task automatic test_both();
    master_read = 1'b1; master_write = 1'b1; master_address = 32'h00001000;
    sb.push_back('{32'hDEADBEEF, 1'b1});
    exp_ec = sat_inc(exp_ec);
    tick(); // cycle 1
    vectors++; if (master_response !== 1'b1) begin miscompares++; $display("FAIL both_resp got %0b want 1", master_response); end
    vectors++; if ({slave_read, slave_write} !== 8'h00) begin miscompares++; $display("FAIL both_strobe got %h want 00", {slave_read, slave_write}); end
    vectors++; if (error_count !== exp_ec) begin miscompares++; $display("FAIL both_ecount got %h want %h", error_count, exp_ec); end
    vectors++;
    if (sb.size() == 0) begin miscompares++; $display("FAIL both_sb got empty want entry"); end
    else begin
      e = sb.pop_front();
      if (master_read_data !== e.data || master_error !== e.err) begin miscompares++; $display("FAIL both_data got %h/%0b want %h/%0b", master_read_data, master_error, e.data, e.err); end
    end
    master_read = 1'b0; master_write = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    master_read = 1'b1; master_address = 32'h00001200;
    sb.push_back('{32'hDEADBEEF, 1'b1});
    exp_ec = sat_inc(exp_ec);
    for (int c = 1; c <= 4; c++) begin
      tick();
      vectors++; if (slave_read !== 4'b0100) begin miscompares++; $display("FAIL to_strobe c%0d got %b want 0100", c, slave_read); end
      vectors++; if (master_response !== 1'b0) begin miscompares++; $display("FAIL to_early_resp c%0d got %0b want 0", c, master_response); end
    end
    tick(); // cycle 5
    vectors++; if (master_response !== 1'b1) begin miscompares++; $display("FAIL to_resp got %0b want 1", master_response); end
    vectors++; if (slave_read !== 4'b0000) begin miscompares++; $display("FAIL to_strobe_drop got %b want 0000", slave_read); end
    vectors++; if (error_count !== exp_ec) begin miscompares++; $display("FAIL to_ecount got %h want %h", error_count, exp_ec); end
    vectors++;
    if (sb.size() == 0) begin miscompares++; $display("FAIL to_sb got empty want entry"); end
    else begin
      e = sb.pop_front();
      if (master_read_data !== e.data || master_error !== e.err) begin miscompares++; $display("FAIL to_data got %h/%0b want %h/%0b", master_read_data, master_error, e.data, e.err); end
    end
    master_read = 1'b0;
    tick(); // idle again; late response from slave 2 must be ignored
    slave_read_data[95:64] = 32'h12345678;
    slave_response = 4'b0100;
    tick();
    vectors++; if (master_response !== 1'b0 || slave_read !== 4'b0000) begin miscompares++; $display("FAIL to_late got %0b/%b want 0/0000", master_response, slave_read); end
    vectors++; if (error_count !== exp_ec) begin miscompares++; $display("FAIL to_late_ecount got %h want %h", error_count, exp_ec); end
    slave_response = 4'b0000;
    tick();
    vectors++; if (master_response !== 1'b0) begin miscompares++; $display("FAIL to_late_resp got %0b want 0", master_response); end
  endtask

  task automatic test_reset_mid();
    master_read = 1'b1; master_address = 32'h00001300;
    tick(); // cycle 1
    vectors++; if (slave_read !== 4'b1000) begin miscompares++; $display("FAIL rm_strobe got %b want 1000", slave_read); end
    tick(); // cycle 2
    rst = 1'b1;
    tick();
    vectors++; if ({slave_read, slave_write} !== 8'h00) begin miscompares++; $display("FAIL rm_strobes got %h want 00", {slave_read, slave_write}); end
    vectors++; if (master_response !== 1'b0) begin miscompares++; $display("FAIL rm_resp got %0b want 0", master_response); end
    vectors++; if (error_count !== 8'h00) begin miscompares++; $display("FAIL rm_ecount got %h want 00", error_count); end
    exp_ec = 8'd0;
    sb.delete();
    rst = 1'b0; master_read = 1'b0;
    tick();
    // fabric must be back in IDLE and accept a fresh zero-wait read
    master_read = 1'b1; master_address = 32'h00001010;
    slave_read_data[31:0] = 32'h0BADCAFE;
    sb.push_back('{32'h0BADCAFE, 1'b0});
    tick();
    vectors++; if (slave_read !== 4'b0001) begin miscompares++; $display("FAIL rm_new_strobe got %b want 0001", slave_read); end
    slave_response = 4'b0001;
    tick();
    slave_response = 4'b0000;
    vectors++; if (master_response !== 1'b1) begin miscompares++; $display("FAIL rm_new_resp got %0b want 1", master_response); end
    vectors++;
    if (sb.size() == 0) begin miscompares++; $display("FAIL rm_sb got empty want entry"); end
    else begin
      e = sb.pop_front();
      if (master_read_data !== e.data || master_error !== e.err) begin miscompares++; $display("FAIL rm_data got %h/%0b want %h/%0b", master_read_data, master_error, e.data, e.err); end
    end
    master_read = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d0, d1;
    d0 = $urandom;
    d1 = $urandom;
    slave_read_data[31:0]   = d0;
    slave_read_data[127:96] = d1;
    master_read = 1'b1; master_address = 32'h00001020;
    sb.push_back('{d0, 1'b0});
    tick(); // cycle 1
    slave_response = 4'b0001;
    tick(); // cycle 2: response; request held and retargeted
    slave_response = 4'b0000;
    vectors++; if (master_response !== 1'b1) begin miscompares++; $display("FAIL b2b_resp0 got %0b want 1", master_response); end
    vectors++;
    if (sb.size() == 0) begin miscompares++; $display("FAIL b2b_sb0 got empty want entry"); end
    else begin
      e = sb.pop_front();
      if (master_read_data !== e.data || master_error !== e.err) begin miscompares++; $display("FAIL b2b_data0 got %h/%0b want %h/%0b", master_read_data, master_error, e.data, e.err); end
    end
    master_address = 32'h00001304;
    sb.push_back('{d1, 1'b0});
    tick(); // cycle 3: IDLE
    vectors++; if (slave_read !== 4'b0000 || master_response !== 1'b0) begin miscompares++; $display("FAIL b2b_idle got %b/%0b want 0000/0", slave_read, master_response); end
    tick(); // cycle 4
    vectors++; if (slave_read !== 4'b1000) begin miscompares++; $display("FAIL b2b_strobe1 got %b want 1000", slave_read); end
    slave_response = 4'b1000;
    tick(); // cycle 5
    slave_response = 4'b0000;
    vectors++; if (master_response !== 1'b1) begin miscompares++; $display("FAIL b2b_resp1 got %0b want 1", master_response); end
    vectors++;
    if (sb.size() == 0) begin miscompares++; $display("FAIL b2b_sb1 got empty want entry"); end
    else begin
      e = sb.pop_front();
      if (master_read_data !== e.data || master_error !== e.err) begin miscompares++; $display("FAIL b2b_data1 got %h/%0b want %h/%0b", master_read_data, master_error, e.data, e.err); end
    end
    master_read = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 260; i++) begin
      master_read = 1'b1; master_address = 32'h00002000 + 32'(i * 4);
      sb.push_back('{32'hDEADBEEF, 1'b1});
      exp_ec = sat_inc(exp_ec);
      tick();
      vectors++;
      if (master_response !== 1'b1 || sb.size() == 0) begin miscompares++; $display("FAIL sat_resp i%0d got %0b want 1", i, master_response); end
      else begin
        e = sb.pop_front();
        if (master_read_data !== e.data || master_error !== e.err) begin miscompares++; $display("FAIL sat_data i%0d got %h/%0b want %h/%0b", i, master_read_data, master_error, e.data, e.err); end
      end
      vectors++; if (error_count !== exp_ec) begin miscompares++; $display("FAIL sat_ecount i%0d got %h want %h", i, error_count, exp_ec); end
      master_read = 1'b0;
      tick();
    end
    vectors++; if (error_count !== 8'hFF) begin miscompares++; $display("FAIL sat_final got %h want FF", error_count); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_unmapped();
    test_both();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_saturation();
    vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL sb_leftover got %0d want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
